// File: rtl/tri_scan_pkg.sv
// tri_scan_pkg: shared defaults, FSM state and coordinate types for the raster scanner
package tri_scan_pkg;
   localparam int DEF_COORD_W = 12;
   localparam int DEF_GRID_W  = 48;
   localparam int DEF_GRID_H  = 64;
   typedef enum logic [1:0] {ST_IDLE, ST_BBOX, ST_SCAN, ST_DONE} state_t;
   typedef logic [DEF_COORD_W-1:0] coord_t;
endpackage

// File: rtl/tri_bbox.sv
// tri_bbox: combinational vertex bounding box clipped to the 1-based grid
module tri_bbox
   import tri_scan_pkg::*;
#(
   parameter int COORD_W = DEF_COORD_W,
   parameter int GRID_W  = DEF_GRID_W,
   parameter int GRID_H  = DEF_GRID_H
) (
   input  logic [COORD_W-1:0] x1,
   input  logic [COORD_W-1:0] y1,
   input  logic [COORD_W-1:0] x2,
   input  logic [COORD_W-1:0] y2,
   input  logic [COORD_W-1:0] x3,
   input  logic [COORD_W-1:0] y3,
   output logic [COORD_W-1:0] xmin,
   output logic [COORD_W-1:0] xmax,
   output logic [COORD_W-1:0] ymin,
   output logic [COORD_W-1:0] ymax
);
   localparam logic [COORD_W-1:0] ONE = COORD_W'(1);
   localparam logic [COORD_W-1:0] GW  = COORD_W'(GRID_W);
   localparam logic [COORD_W-1:0] GH  = COORD_W'(GRID_H);
   logic [COORD_W-1:0] xa, xb, ya, yb, xlo, xhi, ylo, yhi;
   // min/max over the three vertices, then clamp into [1, GRID]
   always_comb begin
      xa   = (x1 < x2) ? x1 : x2;
      xb   = (x1 > x2) ? x1 : x2;
      ya   = (y1 < y2) ? y1 : y2;
      yb   = (y1 > y2) ? y1 : y2;
      xlo  = (x3 < xa) ? x3 : xa;
      xhi  = (x3 > xb) ? x3 : xb;
      ylo  = (y3 < ya) ? y3 : ya;
      yhi  = (y3 > yb) ? y3 : yb;
      xmin = (xlo < ONE) ? ONE : xlo;
      xmax = (xhi > GW) ? GW : xhi;
      ymin = (ylo < ONE) ? ONE : ylo;
      ymax = (yhi > GH) ? GH : yhi;
   end
endmodule

// File: rtl/tri_raster_scan.sv
// tri_raster_scan: scans a triangle's pixel range x-outer/y-inner; TRI_SCAN_BBOX_EN enables bbox clipping
module tri_raster_scan
   import tri_scan_pkg::*;
#(
   parameter int COORD_W = DEF_COORD_W,
   parameter int GRID_W  = DEF_GRID_W,
   parameter int GRID_H  = DEF_GRID_H
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               tri_valid,
   output logic               tri_ready,
   input  logic [COORD_W-1:0] x1,
   input  logic [COORD_W-1:0] y1,
   input  logic [COORD_W-1:0] x2,
   input  logic [COORD_W-1:0] y2,
   input  logic [COORD_W-1:0] x3,
   input  logic [COORD_W-1:0] y3,
   output logic               pix_valid,
   input  logic               pix_ready,
   output logic [COORD_W-1:0] pix_x,
   output logic [COORD_W-1:0] pix_y,
   output logic [COORD_W-1:0] vx1,
   output logic [COORD_W-1:0] vy1,
   output logic [COORD_W-1:0] vx2,
   output logic [COORD_W-1:0] vy2,
   output logic [COORD_W-1:0] vx3,
   output logic [COORD_W-1:0] vy3,
   output logic               pix_last,
   output logic               done,
   output logic               busy
);
   localparam logic [COORD_W-1:0] ONE = COORD_W'(1);
   state_t state_q, state_d;
   logic [5:0][COORD_W-1:0] vtx_q, vtx_d;
   // rng[0]=xmin, rng[1]=xmax, rng[2]=ymin, rng[3]=ymax
   logic [3:0][COORD_W-1:0] rng_q, rng_d;
   logic [COORD_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
   logic [COORD_W-1:0] xmin_w, xmax_w, ymin_w, ymax_w;
   logic empty, fire, y_end;
`ifdef TRI_SCAN_BBOX_EN
   tri_bbox #(.COORD_W(COORD_W), .GRID_W(GRID_W), .GRID_H(GRID_H)) u_bbox (
      .x1(vtx_q[0]), .y1(vtx_q[1]), .x2(vtx_q[2]), .y2(vtx_q[3]), .x3(vtx_q[4]), .y3(vtx_q[5]),
      .xmin(xmin_w), .xmax(xmax_w), .ymin(ymin_w), .ymax(ymax_w)
   );
`else
   assign xmin_w = ONE;
   assign xmax_w = COORD_W'(GRID_W);
   assign ymin_w = ONE;
   assign ymax_w = COORD_W'(GRID_H);
`endif
   assign empty = (xmin_w > xmax_w) || (ymin_w > ymax_w);
   assign fire  = pix_valid && pix_ready;
   assign y_end = pix_y_q == rng_q[3];
   assign pix_x = pix_x_q;
   assign pix_y = pix_y_q;
   assign {vy3, vx3, vy2, vx2, vy1, vx1} = vtx_q;
   // state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else state_q <= state_d;
   end
   // next-state: BBOX always lasts one cycle, DONE always returns to IDLE
   always_comb begin
      state_d = (state_q == ST_IDLE) ? (tri_valid ? ST_BBOX : ST_IDLE) :
                (state_q == ST_BBOX) ? (empty ? ST_DONE : ST_SCAN) :
                (state_q == ST_SCAN) ? ((fire && pix_last) ? ST_DONE : ST_SCAN) : ST_IDLE;
   end
   // state-decoded outputs; pix_last only meaningful while scanning
   always_comb begin
      tri_ready = state_q == ST_IDLE;
      busy      = state_q != ST_IDLE;
      pix_valid = state_q == ST_SCAN;
      done      = state_q == ST_DONE;
      pix_last  = pix_valid && (pix_x_q == rng_q[1]) && y_end;
   end
   // datapath next values: latch vertices, register range in BBOX, step y then x on handshake
   always_comb begin
      vtx_d   = (tri_valid && tri_ready) ? {y3, x3, y2, x2, y1, x1} : vtx_q;
      rng_d   = (state_q == ST_BBOX) ? {ymax_w, ymin_w, xmax_w, xmin_w} : rng_q;
      pix_x_d = (state_q == ST_BBOX) ? xmin_w :
                (fire && !pix_last && y_end) ? pix_x_q + ONE : pix_x_q;
      pix_y_d = (state_q == ST_BBOX) ? ymin_w :
                (fire && !pix_last) ? (y_end ? rng_q[2] : pix_y_q + ONE) : pix_y_q;
   end
   // datapath registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vtx_q   <= '0;
         rng_q   <= '0;
         pix_x_q <= '0;
         pix_y_q <= '0;
      end else begin
         vtx_q   <= vtx_d;
         rng_q   <= rng_d;
         pix_x_q <= pix_x_d;
         pix_y_q <= pix_y_d;
      end
   end
endmodule

// File: tb/tb_tri_raster_scan.sv
// tb_tri_raster_scan: scoreboard bench; expected ranges follow TRI_SCAN_BBOX_EN
module tb_tri_raster_scan;
   localparam int CW = 12;
`ifdef TRI_SCAN_BBOX_EN
   localparam int A_XN = 12,  A_XX = 15, A_YN = 15,  A_YX = 25, A_NX = 12, A_NY = 20;
   localparam int C_XN = 40,  C_XX = 48, C_YN = 60,  C_YX = 64;
   localparam int E_XN = 100, E_XX = 48, E_YN = 100, E_YX = 64;
`else
   localparam int A_XN = 1, A_XX = 48, A_YN = 1, A_YX = 64, A_NX = 1, A_NY = 6;
   localparam int C_XN = 1, C_XX = 48, C_YN = 1, C_YX = 64;
   localparam int E_XN = 1, E_XX = 48, E_YN = 1, E_YX = 64;
`endif
   logic clk = 1'b0;
   logic rst_n, tri_valid, tri_ready, pix_valid, pix_ready, pix_last, done, busy;
   logic [CW-1:0] x1, y1, x2, y2, x3, y3, pix_x, pix_y, vx1, vy1, vx2, vy2, vx3, vy3;
   typedef struct {int x; int y; bit last;} pix_t;
   pix_t exp_q[$];
   pix_t mon_e;
   int exp_v[6];
   int n_chk = 0, n_fail = 0, n_pop = 0;
   bit chk_done = 1'b0;

   tri_raster_scan dut (
      .clock(clk), .reset_n(rst_n), .tri_valid(tri_valid), .tri_ready(tri_ready),
      .x1(x1), .y1(y1), .x2(x2), .y2(y2), .x3(x3), .y3(y3),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
      .vx1(vx1), .vy1(vy1), .vx2(vx2), .vy2(vy2), .vx3(vx3), .vy3(vy3),
      .pix_last(pix_last), .done(done), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // monitor: pop and compare on every pixel handshake
   always @(negedge clk) begin
      if (chk_done) begin
         chk("done_after_last", done, 1);
         chk_done = 1'b0;
      end
      if (rst_n && pix_valid && pix_ready) begin
         if (exp_q.size() == 0) chk("unexpected_pixel", 1, 0);
         else begin
            mon_e = exp_q.pop_front();
            chk("pix_x", pix_x, mon_e.x);
            chk("pix_y", pix_y, mon_e.y);
            chk("pix_last", pix_last, mon_e.last);
            chk("vertices_held", int'(vx1 == exp_v[0] && vy1 == exp_v[1] && vx2 == exp_v[2] &&
                                      vy2 == exp_v[3] && vx3 == exp_v[4] && vy3 == exp_v[5]), 1);
            if (mon_e.last) chk_done = 1'b1;
         end
         n_pop++;
      end
   end

   task automatic run_tri(input int ax1, ay1, ax2, ay2, ax3, ay3, xmn, xmx, ymn, ymx,
                          input int stall_idx, nx, ny, rst_idx);
      bit empty;
      int sx, sy;
      pix_t p;
      empty = (xmn > xmx) || (ymn > ymx);
      @(posedge clk); #1;
      x1 = CW'(ax1); y1 = CW'(ay1); x2 = CW'(ax2); y2 = CW'(ay2); x3 = CW'(ax3); y3 = CW'(ay3);
      tri_valid = 1'b1;
      exp_v = '{ax1, ay1, ax2, ay2, ax3, ay3};
      n_pop = 0;
      if (!empty)
         for (int x = xmn; x <= xmx; x++)
            for (int y = ymn; y <= ymx; y++) begin
               p.x = x; p.y = y; p.last = (x == xmx) && (y == ymx);
               exp_q.push_back(p);
            end
      @(posedge clk); #1;
      tri_valid = 1'b0;
      chk("bbox_tri_ready", tri_ready, 0);
      chk("bbox_busy", busy, 1);
      chk("bbox_pix_valid", pix_valid, 0);
      chk("vx1_latched", vx1, ax1);
      chk("vy3_latched", vy3, ay3);
      @(posedge clk); #1;
      if (empty) begin
         chk("empty_pix_valid", pix_valid, 0);
         chk("empty_done", done, 1);
         @(posedge clk); #1;
         chk("empty_tri_ready", tri_ready, 1);
         chk("empty_done_pulse", done, 0);
         return;
      end
      chk("first_pix_valid", pix_valid, 1);
      for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
         if (n_pop == rst_idx && pix_valid) begin
            rst_n = 1'b0;
            #1;
            chk("rst_pix_valid", pix_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_tri_ready", tri_ready, 1);
            chk("rst_vx1", vx1, 0);
            exp_q.delete();
            @(posedge clk); #1;
            rst_n = 1'b1;
            return;
         end
         if (n_pop == stall_idx && pix_valid) begin
            sx = pix_x; sy = pix_y;
            pix_ready = 1'b0;
            tri_valid = 1'b1;
            x1 = 100; y1 = 100; x2 = 110; y2 = 100; x3 = 100; y3 = 120;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               chk("stall_valid", pix_valid, 1);
               chk("stall_x", pix_x, sx);
               chk("stall_y", pix_y, sy);
               tri_valid = 1'b0;
            end
            @(posedge clk); #1;
            pix_ready = 1'b1;
            @(posedge clk); #1;
            chk("resume_x", pix_x, nx);
            chk("resume_y", pix_y, ny);
            stall_idx = -1;
         end
         @(posedge clk); #1;
      end
      chk("done_seen", done, 1);
      chk("scoreboard_empty", exp_q.size(), 0);
      @(posedge clk); #1;
      chk("idle_tri_ready", tri_ready, 1);
      chk("idle_done_pulse", done, 0);
      repeat (3) begin
         @(negedge clk);
         chk("idle_busy", busy, 0);
      end
   endtask

   initial begin
      rst_n = 1'b0; tri_valid = 1'b0; pix_ready = 1'b1;
      x1 = '0; y1 = '0; x2 = '0; y2 = '0; x3 = '0; y3 = '0;
      #3;
      chk("rst_tri_ready", tri_ready, 1);
      chk("rst_pix_valid", pix_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pix_last", pix_last, 0);
      chk("rst_pix_x", pix_x, 0);
      chk("rst_pix_y", pix_y, 0);
      chk("rst_vx1", vx1, 0);
      chk("rst_vy3", vy3, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      run_tri(12, 15, 12, 25, 15, 15, A_XN, A_XX, A_YN, A_YX, 4, A_NX, A_NY, -1);
      run_tri(12, 15, 12, 25, 15, 15, A_XN, A_XX, A_YN, A_YX, -1, 0, 0, 9);
      run_tri(40, 60, 60, 70, 45, 80, C_XN, C_XX, C_YN, C_YX, -1, 0, 0, -1);
      run_tri(100, 100, 110, 100, 100, 120, E_XN, E_XX, E_YN, E_YX, -1, 0, 0, -1);
      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule

// File: doc/tri_raster_scan.md
TRI_RASTER_SCAN -- requirements
Module: tri_raster_scan

Interface
REQ-001 The block SHALL have these parameters, given as name, default, meaning:
- COORD_W, 12, coordinate width in bits.
- GRID_W, 48, grid columns (x = 1..GRID_W).
- GRID_H, 64, grid rows (y = 1..GRID_H).

REQ-002 The block SHALL have these ports, given as name, direction, width, meaning:
- clock, input, 1, single clock; all state updates on rising edge.
- reset_n, input, 1, asynchronous, active-low reset.
- tri_valid, input, 1, triangle vertex set offered.
- tri_ready, output, 1, block accepts a triangle.
- x1, y1, x2, y2, x3, y3, input, COORD_W each, triangle vertices (unsigned).
- pix_valid, output, 1, pixel coordinate offered to the inside-test stage.
- pix_ready, input, 1, downstream accepts the pixel.
- pix_x, pix_y, output, COORD_W each, current pixel coordinate.
- vx1, vy1, vx2, vy2, vx3, vy3, output, COORD_W each, latched vertices, stable for the whole scan.
- pix_last, output, 1, marks the final pixel of the scan.
- done, output, 1, one-cycle pulse at scan end.
- busy, output, 1, high in any state other than IDLE.

Function
REQ-003 The FSM SHALL have four states, IDLE, BBOX, SCAN and DONE, with these transitions:
- IDLE to BBOX on tri_valid && tri_ready.
- BBOX to SCAN, or BBOX to DONE if the scan range is empty.
- SCAN to DONE on a handshake with pix_last=1.
- DONE to IDLE unconditionally.

REQ-004 tri_ready SHALL be 1 only in IDLE; tri_valid SHALL be ignored in all other states.

REQ-005 On acceptance, x1..y3 SHALL be registered into vx1..vy3 and held unchanged until the next acceptance.

REQ-006 The BBOX state SHALL take exactly one cycle and compute the scan range [xmin, xmax] x [ymin, ymax].

REQ-007 The first pix_valid SHALL assert two cycles after the accepting edge.

REQ-008 Scan order SHALL be x outer and y inner: y increments from ymin to ymax, then resets to ymin while x increments.

REQ-009 pix_x, pix_y and pix_last SHALL advance only on pix_valid && pix_ready, and SHALL be held stable while pix_valid=1 and pix_ready=0.

REQ-010 pix_valid SHALL remain 1 for the whole SCAN state (one pixel per cycle under continuous pix_ready) and be 0 in all other states.

REQ-011 pix_last SHALL be 1 exactly when pix_x=xmax and pix_y=ymax.

REQ-012 done SHALL be 1 only in the DONE state, for exactly one cycle.

REQ-013 If the range is empty (xmin>xmax or ymin>ymax), the block SHALL emit no pixel and go BBOX to DONE; done then asserts two cycles after acceptance.

REQ-014 Counters SHALL be COORD_W wide, compare against range bounds, and never wrap past GRID_W or GRID_H.

Reset
REQ-015 reset_n=0 SHALL asynchronously force these values:
- state IDLE.
- pix_valid=0, pix_last=0, done=0, busy=0, tri_ready=1.
- pix_x=0, pix_y=0, vx1..vy3=0.

REQ-016 Reset asserted mid-scan SHALL abandon the scan with no further pixels; the first triangle after release SHALL scan normally.

Configuration
REQ-017 With TRI_SCAN_BBOX_EN defined, the range SHALL be the vertex bounding box clipped to the grid:
- xmin = max(min(x1,x2,x3), 1) and xmax = min(max(x1,x2,x3), GRID_W).
- ymin and ymax are computed likewise against GRID_H.

REQ-018 Without TRI_SCAN_BBOX_EN, the range SHALL be the full grid [1, GRID_W] x [1, GRID_H] regardless of the vertices, and the empty case SHALL never occur.

Structure
REQ-019 A shared package tri_scan_pkg SHALL hold the following; the block SHALL import it:
- COORD_W, GRID_W, GRID_H defaults.
- The FSM state enum typedef.
- A coordinate typedef.

REQ-020 The min/max/clip logic SHALL be a combinational sub-module tri_bbox, instantiated only when TRI_SCAN_BBOX_EN is defined; its output SHALL be registered in BBOX.

Verification
REQ-021 With BBOX_EN, triangle (12,15),(12,25),(15,15) under constant pix_ready -> required response:
- 44 pixels (x 12..15, y 15..25).
- First pixel (12,15) two cycles after accept; last (15,25) with pix_last=1.
- done pulses the following cycle.

REQ-022 Without BBOX_EN, the same triangle -> required response:
- 3072 pixels, first (1,1), last (48,64).
- vx1..vy3 = 12,15,12,25,15,15 throughout.

REQ-023 Triangle (40,60),(60,70),(45,80) -> required response:
- Clipped to x 40..48 and y 60..64, giving 45 pixels.
- Last pixel (48,64).

REQ-024 Triangle (100,100),(110,100),(100,120) with BBOX_EN -> required response:
- pix_valid never asserts.
- done pulses two cycles after accept; tri_ready returns the cycle after.

REQ-025 Backpressure, pix_ready=0 for 3 cycles while (12,19) is presented -> required response:
- pix_x and pix_y are held at (12,19) with pix_valid=1.
- The next pixel (12,20) appears one cycle after pix_ready returns.
- tri_valid pulsed during the scan is not accepted.

REQ-026 reset_n low during the 10th pixel -> required response:
- pix_valid=0 and busy=0 immediately.
- After release, a new triangle scans from its first pixel.
